// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for one pipeline stage register.
// slave: stage side; master: upstream/downstream driver side.
interface pipe_stage_reg_if #(
   parameter int DATA_W = 32
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;

   modport slave (
      input  flush,
      input  in_valid,
      output in_ready,
      input  in_data,
      output out_valid,
      input  out_ready,
      output out_data,
      output occupancy
   );

   modport master (
      output flush,
      output in_valid,
      input  in_ready,
      output in_data,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  occupancy
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready, flush and a 2-entry skid buffer.
// Ports: clk, reset (sync, active-low), bus (pipe_stage_reg_if.slave:
//   flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data, occupancy).
// Optional PIPE_STAGE_PERF_EN adds stall_cnt and flush_cnt outputs.
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic                clk,
   input  logic                reset,
`ifdef PIPE_STAGE_PERF_EN
   output logic [CNT_W-1:0]    stall_cnt,
   output logic [CNT_W-1:0]    flush_cnt,
`endif
   pipe_stage_reg_if.slave     bus
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;

   logic accept;
   logic pop;

   assign accept = bus.in_valid & in_ready_q;
   assign pop    = out_valid_q & bus.out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (bus.flush) begin
         // Data regs keep stale contents; only the valid state clears.
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = ONE;
                  main_d  = bus.in_data;
               end
            end
            ONE: begin
               unique case (1'b1)
                  (accept & pop): begin
                     main_d = bus.in_data;
                  end
                  (accept & ~pop): begin
                     state_d = FULL;
                     skid_d  = bus.in_data;
                  end
                  (~accept & pop): begin
                     state_d = EMPTY;
                  end
                  default: begin
                     state_d = ONE;
                  end
               endcase
            end
            FULL: begin
               // in_ready is low here, so only a pop can move us.
               if (pop) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
      // Handshake outputs come straight from the next state so they
      // leave the block as flops with no input-to-output path.
      in_ready_d  = (state_d != FULL);
      out_valid_d = (state_d != EMPTY);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = main_q;
   assign bus.occupancy = state_q;

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (out_valid_q & ~bus.out_ready) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      // Only flushes that actually discard something are counted.
      if (bus.flush & ((state_q != EMPTY) | bus.in_valid)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

   // A stalled output must hold its payload until popped or flushed.
   a_stall_stable : assert property (
      @(posedge clk) disable iff (!reset)
      (out_valid_q && !bus.out_ready && !bus.flush)
      |=> (out_valid_q && $stable(main_q))
   );

   // Skid entry exists only when input is blocked.
   a_ready_state : assert property (
      @(posedge clk) disable iff (!reset)
      (in_ready_q == (state_q != FULL))
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg.
// Drives and samples 1 time unit after each rising edge.
module tb_pipe_stage_reg;

   logic clk;
   logic reset;

   int n_chk;
   int n_fail;

   pipe_stage_reg_if #(.DATA_W(32)) bus ();

`ifdef PIPE_STAGE_PERF_EN
   logic [3:0] stall_cnt;
   logic [3:0] flush_cnt;

   pipe_stage_reg #(
      .DATA_W(32),
      .CNT_W (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt),
      .bus      (bus.slave)
   );
`else
   pipe_stage_reg #(
      .DATA_W(32),
      .CNT_W (4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;

      // Reset held 2 cycles with in_valid high.
      reset         = 1'b0;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hDEAD;
      bus.out_ready = 1'b0;
      step();
      step();
      chk("rst_ovalid", 32'(bus.out_valid), 32'd0);
      chk("rst_iready", 32'(bus.in_ready), 32'd1);
      chk("rst_occ", 32'(bus.occupancy), 32'd0);
      chk("rst_odata", bus.out_data, 32'h0);
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      step();
      chk("rst_nocap", 32'(bus.occupancy), 32'd0);

      // Streaming at one item per cycle.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 32'h10 + 32'(i);
         step();
         chk("str_ovalid", 32'(bus.out_valid), 32'd1);
         chk("str_odata", bus.out_data, 32'h10 + 32'(i));
         chk("str_iready", 32'(bus.in_ready), 32'd1);
         chk("str_occ", 32'(bus.occupancy), 32'd1);
      end
      bus.in_valid = 1'b0;
      step();
      chk("str_drain", 32'(bus.out_valid), 32'd0);

      // Backpressure fills the skid entry.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hA1;
      step();
      bus.in_data = 32'hA2;
      step();
      bus.in_data = 32'hCC;
      chk("bp_occ", 32'(bus.occupancy), 32'd2);
      chk("bp_iready", 32'(bus.in_ready), 32'd0);
      chk("bp_odata", bus.out_data, 32'hA1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_hold", bus.out_data, 32'hA1);
         chk("bp_hocc", 32'(bus.occupancy), 32'd2);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      chk("bp_pop1", bus.out_data, 32'hA2);
      chk("bp_pop1v", 32'(bus.out_valid), 32'd1);
      chk("bp_rdy", 32'(bus.in_ready), 32'd1);
      chk("bp_occ1", 32'(bus.occupancy), 32'd1);
      step();
      chk("bp_pop2", 32'(bus.out_valid), 32'd0);
      chk("bp_occ0", 32'(bus.occupancy), 32'd0);

      // Flush while FULL with a same-cycle input.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hB1;
      step();
      bus.in_data = 32'hB2;
      step();
      chk("fl_full", 32'(bus.occupancy), 32'd2);
      bus.flush   = 1'b1;
      bus.in_data = 32'hBB;
      step();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("fl_ovalid", 32'(bus.out_valid), 32'd0);
      chk("fl_occ", 32'(bus.occupancy), 32'd0);
      chk("fl_iready", 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("fl_nobb", 32'(bus.out_valid), 32'd0);
      end

      // Flush from ONE during accept and pop.
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hB5;
      step();
      chk("fl1_load", bus.out_data, 32'hB5);
      bus.flush   = 1'b1;
      bus.in_data = 32'hBC;
      step();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("fl1_ovalid", 32'(bus.out_valid), 32'd0);
      chk("fl1_occ", 32'(bus.occupancy), 32'd0);

      // Reset mid-stall with out_ready high.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hC1;
      step();
      bus.in_data = 32'hC2;
      step();
      chk("rs_full", 32'(bus.occupancy), 32'd2);
      bus.in_valid  = 1'b0;
      step();
      reset         = 1'b0;
      bus.out_ready = 1'b1;
      step();
      reset         = 1'b1;
      bus.out_ready = 1'b0;
      chk("rs_occ", 32'(bus.occupancy), 32'd0);
      chk("rs_ovalid", 32'(bus.out_valid), 32'd0);
      chk("rs_iready", 32'(bus.in_ready), 32'd1);
      chk("rs_odata", bus.out_data, 32'h0);
`ifdef PIPE_STAGE_PERF_EN
      chk("rs_stall", 32'(stall_cnt), 32'd0);
      chk("rs_flush", 32'(flush_cnt), 32'd0);

      // 17 stall cycles wrap a 4-bit counter to 1.
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hD1;
      step();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 17; i++) step();
      chk("pf_stall", 32'(stall_cnt), 32'd1);

      // Flush with one entry held; stall still counts that cycle.
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      chk("pf_fl1", 32'(flush_cnt), 32'd1);
      chk("pf_st2", 32'(stall_cnt), 32'd2);

      // Flush while empty and idle is not counted.
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      chk("pf_fl0", 32'(flush_cnt), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register for the pipelined core. Successor to the fixed-field, always-enabled stage registers.
- Adds a valid/ready handshake, stall via backpressure, and flush.
- A 2-entry skid buffer keeps input ready registered (no combinational ready path) at full one-per-cycle throughput.
- Stage fields are concatenated by the instantiating stage into a single payload bus.

Parameters:
- DATA_W, 32: payload width in bits; must be >= 1.
- CNT_W, 32: width of the performance counters; used only when PIPE_STAGE_PERF_EN is defined.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; reset=0 sampled on a rising edge resets the block.
- flush  input  1  discard all held entries and any same-cycle input.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  registered; block can accept this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  registered; out_data is valid.
- out_ready  input  1  downstream accepts; 0 means stall.
- out_data  output  DATA_W  registered payload (main entry).
- occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Storage:
  - main entry (valid bit + data) drives out_*.
  - skid entry (valid bit + data) holds one overflow entry.
  - in_ready = ~skid_valid, registered.
- States: EMPTY (no entries), ONE (main valid), FULL (main + skid valid). occupancy = 0 / 1 / 2 respectively.
- Transitions when reset=1 and flush=0:
  - EMPTY: accept -> ONE, main<=in_data; else stay EMPTY.
  - ONE, accept & pop -> ONE, main<=in_data (pass-through, 1 item/cycle).
  - ONE, accept & ~pop -> FULL, skid<=in_data, in_ready drops next cycle.
  - ONE, ~accept & pop -> EMPTY.
  - ONE, neither -> ONE, main data held stable.
  - FULL: in_ready=0, so no accept. Pop -> ONE, main<=skid; else FULL, both entries held.
- Latency: data accepted at edge N appears on out_data with out_valid=1 after edge N (1 cycle) when the block was EMPTY, or ONE with a pop.
- Ordering: strict FIFO; no reorder, duplication or loss unless flushed.
- Flush (reset=1, flush=1):
  - Next state EMPTY regardless of accept/pop; a same-cycle input is dropped.
  - A same-cycle pop still counts as a transfer downstream, since out_valid was 1 that cycle.
  - Next cycle: out_valid=0, in_ready=1, occupancy=0.
  - Data registers are not cleared; out_data is don't-care while out_valid=0.
- Reset (reset=0 at an edge):
  - Highest priority, overrides flush and any handshake; accept/pop in that cycle have no effect.
  - Reset values: out_valid=0, in_ready=1, occupancy=0, out_data=0, skid data=0, perf counters=0.
  - Reset asserted mid-stall (FULL) empties the block in one edge.
- Stability: while out_valid=1 and out_ready=0, out_data must not change.
- Handshake: in_ready does not depend combinationally on any input. in_valid may drop without a transfer.
- DATA_W=1 must work; no width truncation anywhere.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined, adds two outputs:
  - stall_cnt [CNT_W-1:0]: increments each cycle with out_valid=1 & out_ready=0.
  - flush_cnt [CNT_W-1:0]: increments each cycle with flush=1 while occupancy!=0 or in_valid=1.
- Both counters wrap modulo 2^CNT_W, clear on reset, and are unaffected by flush.
- When undefined: the ports and logic are absent and the rest of the behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, occupancy=0, out_data=0; no entry captured.
- Streaming: out_ready=1, in_data=0x10..0x17 on 8 consecutive cycles -> out_data 0x10..0x17 on the following 8 cycles, in_ready never drops, occupancy stays 1.
- Backpressure:
  - Send 0xA1, 0xA2 with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA1 held for 3 stall cycles.
  - Then out_ready=1 -> pops 0xA1, then 0xA2; in_ready returns to 1 one cycle after the first pop.
- Flush while FULL with in_valid=1 (in_data=0xBB) -> next cycle out_valid=0, occupancy=0, in_ready=1; 0xBB never appears at the output.
- Reset mid-stall: FULL, then reset=0 for one edge simultaneous with out_ready=1 -> EMPTY; no pop counted. With PIPE_STAGE_PERF_EN: stall_cnt=0 afterwards.
- Perf counters (PIPE_STAGE_PERF_EN, CNT_W=4):
  - 17 stall cycles -> stall_cnt=1 (wrap).
  - Flush with occupancy=1 -> flush_cnt=1.
  - Flush with block EMPTY and in_valid=0 -> flush_cnt unchanged.
